pri_enc_arb: RTL and testbench
==============================

PRI_ENC_ARB -- requirements
Module: pri_enc_arb

Interface
REQ-001 Parameter N, default 32, is the number of request lines; the legal range is 2..256.
REQ-002 Parameter W, default $clog2(N), is the index width; it SHALL NOT be overridden independently of N.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 i  input  N  is the request vector; bit k is request k.
REQ-006 in_valid  input  1  indicates that i and mode are valid this cycle.
REQ-007 in_ready  output  1  indicates the block can accept a beat this cycle.
REQ-008 mode  input  1  selects the mode: 0 = fixed priority, 1 = round-robin; it is sampled with the beat.
REQ-009 out  output  W  is the encoded index of the winning request.
REQ-010 gs  output  1  is group select: at least one request was set in the accepted beat.
REQ-011 out_valid  output  1  indicates that out and gs hold a valid result.
REQ-012 out_ready  input  1  indicates the downstream consumer accepts the result.

Function
REQ-013 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-014 in_ready SHALL equal (~out_valid | out_ready), combinationally.
REQ-015 An accepted beat SHALL update out, gs and out_valid=1 on the same edge, giving one-cycle latency.
REQ-016 If no beat is accepted and out_ready=1, out_valid SHALL clear to 0 on the edge; out and gs SHALL hold their values.
REQ-017 While out_valid=1 and out_ready=0, out, gs and out_valid SHALL hold stable.
REQ-018 In fixed mode (mode=0), out SHALL be the highest set index of i, so that i[N-1] has top priority.
REQ-019 In round-robin mode (mode=1), out SHALL be the first set index found by searching downward from last-1, wrapping from 0 to N-1 and ending at last itself.
REQ-020 The register last (W bits) SHALL load out only on an accepted beat with mode=1 and gs=1; in every other case it holds.
REQ-021 If only request last is set in round-robin mode, out SHALL equal last.
REQ-022 An all-zero i SHALL produce out=0, gs=0 and out_valid=1, and last SHALL be unchanged.
REQ-023 gs SHALL equal the OR-reduction of the accepted i.
REQ-024 A mode change SHALL take effect on the beat that carries it; last is retained across mode changes.
REQ-025 Indices SHALL be unsigned; non-power-of-two N SHALL never produce out >= N.

Reset
REQ-026 rst_n=0 SHALL immediately force out_valid=0, out=0, gs=0 and last=0, independent of clk.
REQ-027 While rst_n=0, in_ready SHALL be 1 and no beat SHALL be accepted.
REQ-028 Reset asserted mid-transfer SHALL discard the pending result with no partial update after release.
REQ-029 Because last=0 after reset, the first round-robin search SHALL start at N-1, making it equivalent to fixed priority.

Verification (N=32)
REQ-030 Reset release -> out_valid=0, out=0, gs=0, in_ready=1.
REQ-031 mode=0, i=0x0001_8000, in_valid=1 -> next edge: out=16, gs=1, out_valid=1.
REQ-032 i=0x0000_0000 accepted -> out=0, gs=0, out_valid=1; a following round-robin beat is unaffected.
REQ-033 mode=1, i=0x8000_0001 held for 3 accepted beats after reset -> out=31, 0, 31.
REQ-034 out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0 and out stable for 4 cycles; out_ready=1 -> new beat accepted on the same edge.
REQ-035 rst_n pulsed low between edges while out_valid=1 -> out_valid=0 before the next clk edge; the following round-robin beat with i=0x8000_0001 gives out=31.

Source files
------------

// File: rtl/pri_enc_arb.sv
// rtl/pri_enc_arb.sv - priority encoder / round-robin arbiter with valid/ready handshake
//
// Purpose: encodes an N-bit request vector into the index of the winning
// request. mode=0 picks the highest set index; mode=1 searches downward from
// the previous round-robin winner minus one, wrapping, ending at that winner.
// The result is registered (one-cycle latency) behind a valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   i          request vector, bit k = request k
//   in_valid   i/mode valid this cycle
//   in_ready   block accepts a beat this cycle (~out_valid | out_ready)
//   mode       0 = fixed priority, 1 = round-robin (sampled with the beat)
//   out        encoded winning index
//   gs         at least one request was set in the accepted beat
//   out_valid  out/gs hold a valid result
//   out_ready  downstream accepts the result
module pri_enc_arb #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  output logic [W-1:0] out,
  output logic         gs,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, out_d;
  logic         gs_q, gs_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] last_q, last_d;

  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_lo_idx;
  logic         rr_lo_any;
  logic [W-1:0] rr_idx;
  logic         any_req;
  logic         accept;

  // Index search. Searching downward from last-1 and wrapping to N-1 is the
  // same as taking the highest set bit below last if one exists, otherwise
  // the highest set bit overall (which then lies in [last, N-1]).
  // Indices only ever take loop values k < N, so out never reaches N.
  always_comb begin
    fix_idx   = '0;
    rr_lo_idx = '0;
    rr_lo_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i[k]) begin
        fix_idx = W'(k);
        if (W'(k) < last_q) begin
          rr_lo_idx = W'(k);
          rr_lo_any = 1'b1;
        end
      end
    end
  end

  assign rr_idx   = rr_lo_any ? rr_lo_idx : fix_idx;
  assign any_req  = |i;
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d       = out_q;
    gs_d        = gs_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      gs_d        = any_req;
      out_d       = mode ? rr_idx : fix_idx;
      // An empty beat never moves the round-robin pointer.
      if (mode && any_req) begin
        last_d = rr_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      gs_q        <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= '0;
    end else begin
      out_q       <= out_d;
      gs_q        <= gs_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out       = out_q;
  assign gs        = gs_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pri_enc_arb.sv
// tb/tb_pri_enc_arb.sv - self-checking bench for pri_enc_arb (N=32)
module tb_pri_enc_arb;

  localparam int N = 32;
  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] i;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] out;
  logic         gs;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int failures;

  pri_enc_arb #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out       (out),
    .gs        (gs),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [N-1:0] req;
    logic [W-1:0] exp_out;
    logic         exp_gs;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Continuous sequence from reset (last=0), out_ready held at 1.
    vecs[0]  = '{1'b0, 32'h0001_8000, 5'd16, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_0000, 5'd0,  1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0001, 5'd31, 1'b1}; // last 0 -> 31
    vecs[3]  = '{1'b1, 32'h8000_0001, 5'd0,  1'b1}; // last 31 -> 0
    vecs[4]  = '{1'b1, 32'h8000_0001, 5'd31, 1'b1}; // last 0 -> 31
    vecs[5]  = '{1'b0, 32'h8000_0001, 5'd31, 1'b1}; // last stays 31
    vecs[6]  = '{1'b1, 32'h0000_0000, 5'd0,  1'b0}; // last stays 31
    vecs[7]  = '{1'b1, 32'h8000_0000, 5'd31, 1'b1}; // only last set
    vecs[8]  = '{1'b1, 32'h0000_00F0, 5'd7,  1'b1}; // last -> 7
    vecs[9]  = '{1'b1, 32'h0000_00F0, 5'd6,  1'b1}; // last -> 6
    vecs[10] = '{1'b1, 32'h0000_0081, 5'd0,  1'b1}; // last -> 0
    vecs[11] = '{1'b1, 32'h0000_0081, 5'd7,  1'b1}; // wrap, last -> 7
    vecs[12] = '{1'b0, 32'h0000_0003, 5'd1,  1'b1}; // last stays 7
    vecs[13] = '{1'b1, 32'h0000_0100, 5'd8,  1'b1}; // wrap, last -> 8
    vecs[14] = '{1'b1, 32'hFFFF_FFFF, 5'd7,  1'b1}; // last -> 7
    vecs[15] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1}; // last stays 7

    rst_n     = 1'b0;
    i         = '0;
    in_valid  = 1'b1;
    mode      = 1'b0;
    out_ready = 1'b1;
    i         = 32'h0000_0010;

    // Beats offered during reset must not be accepted.
    step();
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_no_accept", {31'd0, out_valid}, 32'd0);

    in_valid = 1'b0;
    i        = '0;
    #3;
    rst_n = 1'b1;
    step();
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_out", {27'd0, out}, 32'd0);
    check("rel_gs", {31'd0, gs}, 32'd0);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < 16; v++) begin
      in_valid = 1'b1;
      mode     = vecs[v].mode;
      i        = vecs[v].req;
      step();
      check($sformatf("vec%0d_out", v), {27'd0, out}, {27'd0, vecs[v].exp_out});
      check($sformatf("vec%0d_gs", v), {31'd0, gs}, {31'd0, vecs[v].exp_gs});
      check($sformatf("vec%0d_valid", v), {31'd0, out_valid}, 32'd1);
    end

    // Idle with out_ready=1: valid clears, out/gs hold.
    in_valid = 1'b0;
    step();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_out", {27'd0, out}, 32'd31);
    check("idle_gs", {31'd0, gs}, 32'd1);

    // Backpressure: result must hold while out_ready=0.
    in_valid = 1'b1;
    mode     = 1'b0;
    i        = 32'h0000_0010;
    step();
    check("bp_first_out", {27'd0, out}, 32'd4);
    out_ready = 1'b0;
    i         = 32'h0000_0020;
    #1;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("bp_hold_out%0d", c), {27'd0, out}, 32'd4);
      check($sformatf("bp_hold_valid%0d", c), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_new_out", {27'd0, out}, 32'd5);
    check("bp_new_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset between edges while out_valid=1 (last is 7 here).
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_out", {27'd0, out}, 32'd0);
    check("async_gs", {31'd0, gs}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    mode     = 1'b1;
    i        = 32'h8000_0001;
    step();
    check("post_rst_rr0", {27'd0, out}, 32'd31);
    step();
    check("post_rst_rr1", {27'd0, out}, 32'd0);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
